int_hub: RTL

- Memory-mapped interrupt aggregator between the device IRQ lines (Timer0, Timer1, external interrupt) and the CPU's 6-bit HWInt input.
- Latches, masks and acknowledges each source, then drives HWInt.
- Sits on the Bridge like a TC-class peripheral, using the same Addr[31:2]/WE/Din/Dout register port.
- Replaces direct wiring of IRQs into HWInt.

---
 rtl/int_hub_pkg.sv | 27 ++
 rtl/int_hub_if.sv | 14 +
 rtl/int_hub_src.sv | 65 ++++++
 rtl/int_hub.sv | 96 +++++++++
 4 files changed

// File: rtl/int_hub_pkg.sv
// Shared definitions for the int_hub interrupt aggregator: register offsets,
// register reset values and the HWInt source bit assignment.
package int_hub_pkg;

  typedef enum logic [2:0] {
    INT_OFF_PEND = 3'd0,
    INT_OFF_MASK = 3'd1,
    INT_OFF_ACK  = 3'd2,
    INT_OFF_MODE = 3'd3,
    INT_OFF_CNT  = 3'd4
  } int_off_e;

  // MASK resets fully enabled, MODE resets to level, so the hub is a one-cycle pass-through
  localparam logic [31:0] INT_MASK_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MODE_RST = 32'h0000_0000;

  localparam int INT_BIT_TIMER0  = 0;
  localparam int INT_BIT_TIMER1  = 1;
  localparam int INT_BIT_EXT     = 2;
  localparam int INT_BIT_RSVD_LO = 3;
  localparam int INT_BIT_RSVD_HI = 5;

  localparam int INT_NUM_SRC_DEF = 6;

  localparam logic [31:0] INT_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/int_hub_if.sv
// Bridge register port plus device IRQ lines and CPU HWInt for int_hub.
interface int_hub_if #(
  parameter int NUM_SRC = 6
);
  logic [31:2]        Addr;
  logic               WE;
  logic [31:0]        Din;
  logic [31:0]        Dout;
  logic [NUM_SRC-1:0] Src;
  logic [NUM_SRC-1:0] HWInt;

  modport master (output Addr, WE, Din, Src, input Dout, HWInt);
  modport slave  (input Addr, WE, Din, Src, output Dout, HWInt);
endinterface

// File: rtl/int_hub_src.sv
// One interrupt source slice of int_hub: previous-sample, mode, mask and
// pending state with level/edge capture and write-one-to-clear acknowledge.
module int_hub_src #(
  parameter logic MASK_RST = 1'b1,
  parameter logic MODE_RST = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_src,
  input  logic i_mask_we,
  input  logic i_mask_d,
  input  logic i_mode_we,
  input  logic i_mode_d,
  input  logic i_ack,
  output logic o_pend,
  output logic o_mask,
  output logic o_mode,
  output logic o_irq,
  output logic o_edge_set
);

  logic r_src_q;
  logic r_pend;
  logic r_mask;
  logic r_mode;
  logic w_rise;
  logic w_pend_nxt;

  assign w_rise = i_src & ~r_src_q;

  // In edge mode a new rise beats a same-cycle acknowledge
  always_comb begin
    w_pend_nxt = r_pend;
    if (!r_mode) begin
      w_pend_nxt = i_src;
    end else if (w_rise) begin
      w_pend_nxt = 1'b1;
    end else if (i_ack) begin
      w_pend_nxt = 1'b0;
    end else begin
      w_pend_nxt = r_pend;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src_q <= 1'b0;
      r_pend  <= 1'b0;
      r_mask  <= MASK_RST;
      r_mode  <= MODE_RST;
    end else begin
      r_src_q <= i_src;
      r_pend  <= w_pend_nxt;
      r_mask  <= i_mask_we ? i_mask_d : r_mask;
      r_mode  <= i_mode_we ? i_mode_d : r_mode;
    end
  end

  assign o_pend     = r_pend;
  assign o_mask     = r_mask;
  assign o_mode     = r_mode;
  assign o_irq      = r_pend & r_mask;
  assign o_edge_set = r_mode & w_rise & ~r_pend;

endmodule

// File: rtl/int_hub.sv
// int_hub top: register decode, Dout mux and NUM_SRC source slices.
// Optional edge event counter at offset 4 is built when INT_HUB_CNT_EN is defined.
module int_hub
  import int_hub_pkg::*;
#(
  parameter int NUM_SRC = INT_NUM_SRC_DEF
) (
  input  logic      clk,
  input  logic      reset,
  int_hub_if.slave  bus
);

  logic [2:0]         w_off;
  logic               w_mask_we;
  logic               w_mode_we;
  logic               w_ack_we;
  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_mask;
  logic [NUM_SRC-1:0] w_mode;
  logic [NUM_SRC-1:0] w_irq;
  logic [NUM_SRC-1:0] w_edge_set;
  logic [31:0]        w_dout;

  assign w_off     = bus.Addr[4:2];
  assign w_mask_we = bus.WE && (w_off == INT_OFF_MASK);
  assign w_mode_we = bus.WE && (w_off == INT_OFF_MODE);
  assign w_ack_we  = bus.WE && (w_off == INT_OFF_ACK);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    int_hub_src #(
      .MASK_RST (INT_MASK_RST[g]),
      .MODE_RST (INT_MODE_RST[g])
    ) u_src (
      .clk        (clk),
      .reset      (reset),
      .i_src      (bus.Src[g]),
      .i_mask_we  (w_mask_we),
      .i_mask_d   (bus.Din[g]),
      .i_mode_we  (w_mode_we),
      .i_mode_d   (bus.Din[g]),
      .i_ack      (w_ack_we & bus.Din[g]),
      .o_pend     (w_pend[g]),
      .o_mask     (w_mask[g]),
      .o_mode     (w_mode[g]),
      .o_irq      (w_irq[g]),
      .o_edge_set (w_edge_set[g])
    );
  end

`ifdef INT_HUB_CNT_EN
  logic [31:0] r_evcnt;
  logic        w_cnt_we;

  assign w_cnt_we = bus.WE && (w_off == INT_OFF_CNT);

  // Counts cycles with any new edge latch; a clear write wins over a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_evcnt <= 32'h0000_0000;
    end else if (w_cnt_we) begin
      r_evcnt <= 32'h0000_0000;
    end else if ((|w_edge_set) && (r_evcnt != INT_CNT_MAX)) begin
      r_evcnt <= r_evcnt + 32'h0000_0001;
    end else begin
      r_evcnt <= r_evcnt;
    end
  end

  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, bus.Addr[31:5], bus.Din};
`else
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, bus.Addr[31:5], bus.Din, w_edge_set};
`endif

  // Read mux shows pre-write register contents
  always_comb begin
    w_dout = 32'h0000_0000;
    case (w_off)
      INT_OFF_PEND: w_dout = 32'(w_pend);
      INT_OFF_MASK: w_dout = 32'(w_mask);
      INT_OFF_ACK:  w_dout = 32'h0000_0000;
      INT_OFF_MODE: w_dout = 32'(w_mode);
`ifdef INT_HUB_CNT_EN
      INT_OFF_CNT:  w_dout = r_evcnt;
`else
      INT_OFF_CNT:  w_dout = 32'h0000_0000;
`endif
      default:      w_dout = 32'h0000_0000;
    endcase
  end

  assign bus.Dout  = w_dout;
  assign bus.HWInt = w_irq;

endmodule
